// File: rtl/sao_pkg.sv
// rtl/sao_pkg.sv - SAO statistics controller types, component ids and beat-count helper (SAO_STAT_PIX8_EN selects 8 pixels per beat)
package sao_pkg;

`ifdef SAO_STAT_PIX8_EN
    localparam int SAO_N_PIX_DEF = 8;
`else
    localparam int SAO_N_PIX_DEF = 4;
`endif
    localparam int SAO_CTB_LOG2_DEF = 6;

    typedef enum logic [2:0] {
        IDLE,
        RUN_Y,
        RUN_CB,
        RUN_CR,
        DRAIN,
        DONE
    } sao_stat_st_t;

    localparam logic [1:0] CIDX_Y  = 2'd0;
    localparam logic [1:0] CIDX_CB = 2'd1;
    localparam logic [1:0] CIDX_CR = 2'd2;

    // Chroma is 4:2:0, so each chroma plane holds a quarter of the luma samples.
    function automatic int beats_per_comp(input logic [1:0] cidx,
                                          input int ctb_log2 = SAO_CTB_LOG2_DEF,
                                          input int n_pix    = SAO_N_PIX_DEF);
        if (cidx == CIDX_Y)
            return (1 << (2 * ctb_log2)) / n_pix;
        else
            return (1 << (2 * ctb_log2 - 2)) / n_pix;
    endfunction

endpackage

// File: rtl/sao_stat_ctrl.sv
// rtl/sao_stat_ctrl.sv - SAO statistics CTB sequencer over Y/Cb/Cr with drain (SAO_STAT_PIX8_EN selects 8 pixels per beat)
module sao_stat_ctrl
    import sao_pkg::*;
#(
    parameter int N_PIX     = SAO_N_PIX_DEF,
    parameter int CTB_LOG2  = 6,
    parameter int DRAIN_CYC = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rst_n,
    input  logic       start,
    input  logic       pix_valid,
    output logic       pix_req,
    output logic       en_o,
    output logic       isWorking_stat,
    output logic       wait_forPre,
    output logic       not_end,
    output logic       not_end_pre_stage,
    output logic [1:0] cIdx,
    output logic       busy,
    output logic       done
);

    localparam int CW = CTB_LOG2 * 2;
    localparam logic [CW-1:0] LAST_Y     = CW'(beats_per_comp(CIDX_Y,  CTB_LOG2, N_PIX) - 1);
    localparam logic [CW-1:0] LAST_C     = CW'(beats_per_comp(CIDX_CB, CTB_LOG2, N_PIX) - 1);
    localparam logic [CW-1:0] LAST_DRAIN = CW'(DRAIN_CYC - 1);

    sao_stat_st_t  state, state_nxt;
    logic [CW-1:0] cnt;
    logic          in_run;
    logic          beat_last;

    assign in_run    = (state == RUN_Y) || (state == RUN_CB) || (state == RUN_CR);
    assign beat_last = in_run && pix_valid &&
                       (cnt == ((state == RUN_Y) ? LAST_Y : LAST_C));

    // The counter doubles as the drain timer; any state change restarts it.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                cnt <= '0;
            else if ((in_run && pix_valid) || (state == DRAIN))
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN_Y;
            RUN_Y:   if (beat_last) state_nxt = RUN_CB;
            RUN_CB:  if (beat_last) state_nxt = RUN_CR;
            RUN_CR:  if (beat_last) state_nxt = DRAIN;
            DRAIN:   if (cnt == LAST_DRAIN) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix_req           = 1'b0;
        en_o              = 1'b0;
        isWorking_stat    = 1'b0;
        wait_forPre       = 1'b0;
        not_end           = 1'b1;
        not_end_pre_stage = 1'b1;
        cIdx              = CIDX_Y;
        busy              = (state != IDLE);
        done              = 1'b0;
        case (state)
            RUN_Y, RUN_CB, RUN_CR: begin
                pix_req           = pix_valid;
                en_o              = pix_valid;
                isWorking_stat    = pix_valid;
                wait_forPre       = !pix_valid;
                not_end           = !beat_last;
                not_end_pre_stage = !(beat_last && (state == RUN_CR));
                cIdx              = (state == RUN_Y)  ? CIDX_Y :
                                    (state == RUN_CB) ? CIDX_CB : CIDX_CR;
            end
            DRAIN: begin
                en_o = 1'b1;
                cIdx = CIDX_CR;
            end
            DONE: begin
                done = 1'b1;
                cIdx = CIDX_CR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sao_stat_ctrl.sv
// tb/tb_sao_stat_ctrl.sv - self-checking bench for sao_stat_ctrl against a beat-count reference model
module tb_sao_stat_ctrl;

`ifdef SAO_STAT_PIX8_EN
    localparam int NP = 8;
`else
    localparam int NP = 4;
`endif
    localparam int BY    = 4096 / NP;
    localparam int BC    = 1024 / NP;
    localparam int TOT   = BY + 2 * BC;
    localparam int DRAIN = 2;

    logic       clk, arst_n, rst_n, start, pix_valid;
    logic       pix_req, en_o, isWorking_stat, wait_forPre, not_end, not_end_pre_stage, busy, done;
    logic [1:0] cIdx;

    int n_chk, n_err;
    int m_ph, m_k, m_d;
    int since, done_cnt, done_off, en_cnt, wfp_cnt, acc_cnt;
    int ne_q[$];

    sao_stat_ctrl dut (
        .clk(clk), .arst_n(arst_n), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
        .pix_req(pix_req), .en_o(en_o), .isWorking_stat(isWorking_stat), .wait_forPre(wait_forPre),
        .not_end(not_end), .not_end_pre_stage(not_end_pre_stage), .cIdx(cIdx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wire [9:0] outs = {busy, done, en_o, pix_req, isWorking_stat, wait_forPre,
                       not_end, not_end_pre_stage, cIdx};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected outputs from phase and total accepted beats in the CTB.
    function automatic logic [9:0] model_outs(input logic pv);
        logic [1:0] c;
        logic       lst;
        case (m_ph)
            1: begin
                c   = (m_k < BY) ? 2'd0 : (m_k < BY + BC) ? 2'd1 : 2'd2;
                lst = (m_k == BY - 1) || (m_k == BY + BC - 1) || (m_k == TOT - 1);
                return {1'b1, 1'b0, pv, pv, pv, !pv, !(pv && lst), !(pv && m_k == TOT - 1), c};
            end
            2:       return 10'b1_0_1_0_0_0_1_1_10;
            3:       return 10'b1_1_0_0_0_0_1_1_10;
            default: return 10'b0_0_0_0_0_0_1_1_00;
        endcase
    endfunction

    task automatic cyc(input logic s, input logic pv, input logic rn);
        start = s; pix_valid = pv; rst_n = rn;
        #1;
        chk("outs", 32'(outs), 32'(model_outs(pv)));
        if (done === 1'b1) begin done_cnt++; done_off = since; end
        if (en_o === 1'b1) en_cnt++;
        if (wait_forPre === 1'b1) wfp_cnt++;
        if (not_end === 1'b0) ne_q.push_back(m_k);
        since++;
        if (!rn) begin
            m_ph = 0; m_k = 0; m_d = 0;
        end else begin
            case (m_ph)
                0: if (s) begin m_ph = 1; m_k = 0; since = 1; acc_cnt++; end
                1: if (pv) begin m_k++; if (m_k == TOT) begin m_ph = 2; m_d = 0; end end
                2: begin m_d++; if (m_d == DRAIN) m_ph = 3; end
                default: m_ph = 0;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic clr();
        done_cnt = 0; done_off = -1; en_cnt = 0; wfp_cnt = 0; acc_cnt = 0;
        ne_q.delete();
    endtask

    initial begin
        int stall;
        int q0, q1, q2;
        logic pv;
        n_chk = 0; n_err = 0; since = 0;
        clk = 0; arst_n = 0; rst_n = 1; start = 0; pix_valid = 0;
        m_ph = 0; m_k = 0; m_d = 0;
        clr();
        #1 chk("reset_outs", 32'(outs), 32'(10'b0000001100));
        @(negedge clk);
        arst_n = 1;
        repeat (3) cyc(0, 1'($urandom_range(0, 1)), 1);

        // continuous CTB
        clr();
        cyc(1, 1, 1);
        for (int i = 0; i < 5000 && m_ph != 0; i++) cyc(0, 1, 1);
        chk("t1_en_cycles", en_cnt, TOT + DRAIN);
        chk("t1_done_off", done_off, TOT + 3);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_not_end_cnt", ne_q.size(), 3);
        q0 = (ne_q.size() > 0) ? ne_q[0] : -1;
        q1 = (ne_q.size() > 1) ? ne_q[1] : -1;
        q2 = (ne_q.size() > 2) ? ne_q[2] : -1;
        chk("t1_not_end_y", q0, (NP == 4) ? 1023 : 511);
        chk("t1_not_end_cb", q1, (NP == 4) ? 1279 : 639);
        chk("t1_not_end_cr", q2, (NP == 4) ? 1535 : 767);

        // five-cycle stall at Y beat 100
        clr(); stall = 0;
        cyc(1, 1, 1);
        for (int i = 0; i < 5000 && m_ph != 0; i++) begin
            pv = !(m_ph == 1 && m_k == 100 && stall < 5);
            if (!pv) stall++;
            cyc(0, pv, 1);
        end
        chk("t2_wait_cycles", wfp_cnt, 5);
        chk("t2_en_cycles", en_cnt, TOT + DRAIN);
        chk("t2_done_off", done_off, TOT + 3 + 5);

        // sync clear at Cb beat 50, then a full CTB
        clr();
        cyc(1, 1, 1);
        for (int i = 0; i < 5000 && !(m_ph == 1 && m_k == BY + 50); i++) cyc(0, 1, 1);
        cyc(0, 1, 0);
        start = 0; pix_valid = 1; rst_n = 1; #1;
        chk("t3_busy_after_clr", busy, 0);
        chk("t3_cidx_after_clr", cIdx, 0);
        @(negedge clk);
        repeat (4) cyc(0, 1, 1);
        chk("t3_no_done", done_cnt, 0);
        cyc(1, 1, 1);
        for (int i = 0; i < 5000 && m_ph != 0; i++) cyc(0, 1, 1);
        chk("t3_rerun_done_cnt", done_cnt, 1);
        chk("t3_rerun_done_off", done_off, TOT + 3);

        // start during RUN_Y and coincident with done
        clr();
        cyc(1, 1, 1);
        for (int i = 0; i < 5000 && m_ph != 0; i++)
            cyc((m_ph == 1 && m_k == 10) || m_ph == 3, 1, 1);
        repeat (5) cyc(0, 1, 1);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_busy_idle", busy, 0);

        // random valid and random start pulses
        clr();
        for (int i = 0; i < 6000; i++)
            cyc($urandom_range(0, 40) == 0, $urandom_range(0, 3) != 0, 1);
        for (int i = 0; i < 5000 && m_ph != 0; i++)
            cyc(0, $urandom_range(0, 3) != 0, 1);
        chk("t5_done_per_start", done_cnt, acc_cnt);

        // async reset mid-run
        clr();
        cyc(1, 1, 1);
        repeat (20) cyc(0, 1, 1);
        arst_n = 0; #1;
        chk("t6_arst_busy", busy, 0);
        chk("t6_arst_outs", 32'(outs), 32'(10'b0000001100));
        m_ph = 0; m_k = 0; m_d = 0;
        @(negedge clk);
        arst_n = 1;
        repeat (3) cyc(0, 1, 1);
        chk("t6_no_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
